// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a one-word holding register.
// A free-running divider produces OVERSAMPLE ticks per bit. The start bit is
// confirmed at mid-bit, and every later bit is sampled one full bit period after that.
// Completed words go into a valid/ready holding register. The register flags
// overrun when a completed word has to be dropped.
module uart_rx_os #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int WIDTH      = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             overrun_o
);

  localparam int OS_DIV = CLOCK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = $clog2(OS_DIV);
  localparam int SC_W   = $clog2(OVERSAMPLE);
  localparam int BC_W   = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(OS_DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST   = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0]  SC_HALF   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BC_W-1:0]  BC_LAST   = BC_W'(WIDTH - 1);
  localparam logic [BC_W-1:0]  STOP_LAST = BC_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAITHI
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               rx_s_q, rx_s_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SC_W-1:0]    sc_q, sc_d;
  logic [BC_W-1:0]    bc_q, bc_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic [WIDTH-1:0]   dat_q, dat_d;
  logic               valid_q, valid_d;
  logic               par_err_q, par_err_d;
  logic               frm_err_q, frm_err_d;
  logic               ovr_q, ovr_d;

  logic tick, complete, word_ferr, stop_err, par_xor, hs, load, drop;

  // Next-state logic: synchronizer, divider, frame FSM and holding register.
  always_comb begin
    sync1_d   = dat_i;
    rx_s_d    = sync1_q;
    tick      = (div_q == DIV_LAST);
    div_d     = tick ? '0 : div_q + 1'b1;
    state_d   = state_q;
    sc_d      = sc_q;
    bc_d      = bc_q;
    word_d    = word_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    complete  = 1'b0;
    word_ferr = 1'b0;
    stop_err  = ferr_q | ~rx_s_q;
    par_xor   = (^word_q) ^ rx_s_q;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d = S_START;
            sc_d    = '0;
          end
        end
        S_START: begin
          if (sc_q == SC_HALF) begin
            if (rx_s_q) begin
              state_d = S_IDLE;                 // too short to be a start bit
            end else begin
              state_d = S_DATA;
              sc_d    = '0;
              bc_d    = '0;
              perr_d  = 1'b0;
              ferr_d  = 1'b0;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        S_DATA: begin
          if (sc_q == SC_LAST) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (bc_q == BC_W'(i)) word_d[i] = rx_s_q;
            end
            sc_d = '0;
            if (bc_q == BC_LAST) begin
              bc_d    = '0;
              state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              bc_d = bc_q + 1'b1;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        S_PAR: begin
          if (sc_q == SC_LAST) begin
            perr_d  = (PARITY == 1) ? ~par_xor : par_xor;
            sc_d    = '0;
            bc_d    = '0;
            state_d = S_STOP;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        S_STOP: begin
          if (sc_q == SC_LAST) begin
            sc_d = '0;
            if (bc_q == STOP_LAST) begin
              complete  = 1'b1;
              word_ferr = stop_err;
              // a low stop bit may be a break: wait for the line to return high
              state_d   = stop_err ? S_WAITHI : S_IDLE;
            end else begin
              ferr_d = stop_err;
              bc_d   = bc_q + 1'b1;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        S_WAITHI: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    hs   = valid_q & ready_i;
    load = complete & (~valid_q | ready_i);
    drop = complete & valid_q & ~ready_i;

    dat_d     = load ? word_q : dat_q;
    par_err_d = load ? perr_q : par_err_q;
    frm_err_d = load ? word_ferr : frm_err_q;
    valid_d   = load ? 1'b1 : (hs ? 1'b0 : valid_q);
    ovr_d     = drop ? 1'b1 : (hs ? 1'b0 : ovr_q);
  end

  // All state registers, with synchronous reset to the idle/empty condition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      div_q     <= '0;
      sc_q      <= '0;
      bc_q      <= '0;
      word_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      dat_q     <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      div_q     <= div_d;
      sc_q      <= sc_d;
      bc_q      <= bc_d;
      word_q    <= word_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      dat_q     <= dat_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign dat_o        = dat_q;
  assign valid_o      = valid_q;
  assign parity_err_o = par_err_q;
  assign frame_err_o  = frm_err_q;
  assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os. It drives two instances: 8N1 on line_m and 8E1 on line_p.
// Each frame the bench sends is turned into the word the receiver must deliver.
// The expected word is computed from the bit pattern on the line.
// A compare process checks every newly presented word against that queue,
// including its latency from the start-bit edge.
module tb_uart_rx_os;
  localparam int BIT    = 160;      // clocks per bit (OS_DIV=10, OVERSAMPLE=16)
  localparam int BASE_M = 9 * BIT + BIT / 2;   // start-detect to stop sample, 8N1
  localparam int BASE_P = 10 * BIT + BIT / 2;  // same with a parity bit

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line_m = 1'b1, line_p = 1'b1;
  logic ready_m = 1'b1, ready_p = 1'b1;
  logic [7:0] dat_m, dat_p;
  logic valid_m, valid_p, perr_m, perr_p, ferr_m, ferr_p, ovr_m, ovr_p;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_os #(.CLOCK_FREQ(1_600_000), .BAUD(10_000), .WIDTH(8), .PARITY(0),
               .STOP_BITS(1), .OVERSAMPLE(16)) dut (
    .clk_i(clk), .rst_i(rst), .dat_i(line_m), .dat_o(dat_m), .valid_o(valid_m),
    .ready_i(ready_m), .parity_err_o(perr_m), .frame_err_o(ferr_m), .overrun_o(ovr_m));

  uart_rx_os #(.CLOCK_FREQ(1_600_000), .BAUD(10_000), .WIDTH(8), .PARITY(2),
               .STOP_BITS(1), .OVERSAMPLE(16)) dut_p (
    .clk_i(clk), .rst_i(rst), .dat_i(line_p), .dat_o(dat_p), .valid_o(valid_p),
    .ready_i(ready_p), .parity_err_o(perr_p), .frame_err_o(ferr_p), .overrun_o(ovr_p));

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         start;
  } exp_t;

  exp_t q_m[$];
  exp_t q_p[$];
  int tests = 0;
  int fails = 0;
  int vcyc_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_word(input string tag, input exp_t e, input logic [7:0] d,
                          input logic pe, input logic fe, input logic ov, input int base);
    int lat;
    lat = cyc - e.start;
    tests++;
    if (lat < base + 2 || lat > base + 13) begin
      fails++;
      $display("FAIL %s latency: got %0d required %0d..%0d", tag, lat, base + 2, base + 13);
    end
    chk({tag, " data"}, 32'(d), 32'(e.data));
    chk({tag, " parity_err"}, 32'(pe), 32'(e.perr));
    chk({tag, " frame_err"}, 32'(fe), 32'(e.ferr));
    chk({tag, " overrun"}, 32'(ov), 32'd0);
    $display("[TB] %s word %02h perr=%0b ferr=%0b latency=%0d", tag, d, pe, fe, lat);
  endtask

  // Compare process: a new word is valid rising, or valid still high after a handshake.
  initial begin
    logic pv_m, phs_m, pv_p, phs_p;
    exp_t e;
    pv_m = 0; phs_m = 0; pv_p = 0; phs_p = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv_m = 0; phs_m = 0; pv_p = 0; phs_p = 0;
      end else begin
        if (valid_m) vcyc_m++;
        if (valid_m && (!pv_m || phs_m)) begin
          if (q_m.size() == 0) begin
            tests++; fails++;
            $display("FAIL m unexpected word: got %02h required none", dat_m);
          end else begin
            e = q_m.pop_front();
            cmp_word("m", e, dat_m, perr_m, ferr_m, ovr_m, BASE_M);
          end
        end
        if (valid_p && (!pv_p || phs_p)) begin
          if (q_p.size() == 0) begin
            tests++; fails++;
            $display("FAIL p unexpected word: got %02h required none", dat_p);
          end else begin
            e = q_p.pop_front();
            cmp_word("p", e, dat_p, perr_p, ferr_p, ovr_p, BASE_P);
          end
        end
        pv_m = valid_m; phs_m = valid_m & ready_m;
        pv_p = valid_p; phs_p = valid_p & ready_p;
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) line_p = v;
    else line_m = v;
  endtask

  // Send one frame; the expected word follows from the bits placed on the line.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic par_bit, input logic stop_v, input bit push,
                            input int hold_low_bits);
    exp_t e;
    e.data  = d;
    e.perr  = use_par ? ((^d) ^ par_bit) : 1'b0;   // even parity
    e.ferr  = ~stop_v;
    e.start = cyc;
    if (push) begin
      if (sel) q_p.push_back(e);
      else q_m.push_back(e);
    end
    drive(sel, 1'b0);
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      wait_clks(BIT);
    end
    if (use_par) begin
      drive(sel, par_bit);
      wait_clks(BIT);
    end
    drive(sel, stop_v);
    wait_clks(BIT);
    if (hold_low_bits > 0) wait_clks(hold_low_bits * BIT);
    drive(sel, 1'b1);
  endtask

  initial begin
    int v0;
    exp_t e;
    logic [7:0] d;
    logic [7:0] pat;

    wait_clks(5);
    chk("reset valid_o", 32'(valid_m), 32'd0);
    chk("reset dat_o", 32'(dat_m), 32'd0);
    chk("reset parity_err_o", 32'(perr_m), 32'd0);
    chk("reset frame_err_o", 32'(ferr_m), 32'd0);
    chk("reset overrun_o", 32'(ovr_m), 32'd0);
    chk("reset p valid_o", 32'(valid_p), 32'd0);
    rst = 1'b0;
    wait_clks(3 * BIT);

    // 0xA5, ready high: a single valid cycle, word held afterwards
    v0 = vcyc_m;
    send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1, 0);
    wait_clks(20);
    chk("A5 valid cycles", 32'(vcyc_m - v0), 32'd1);
    chk("A5 dat hold", 32'(dat_m), 32'hA5);
    chk("A5 frame_err", 32'(ferr_m), 32'd0);
    chk("A5 valid low", 32'(valid_m), 32'd0);

    // random 8N1 frames, occasionally with a bad stop bit
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(0, d, 0, 1'b0, ($urandom_range(0, 3) != 0), 1, 0);
      wait_clks($urandom_range(20, 200));
    end

    // break: low stop bit, line kept low for 5 more bit times -> one word only
    send_frame(0, 8'h00, 0, 1'b0, 1'b0, 1, 5);
    chk("break frame_err", 32'(ferr_m), 32'd1);
    chk("break dat", 32'(dat_m), 32'h00);
    wait_clks(2 * BIT);
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 1, 0);
    wait_clks(2 * BIT);
    chk("after break frame_err", 32'(ferr_m), 32'd0);

    // 40-clock glitch is rejected, then 0x3C
    drive(0, 1'b0);
    wait_clks(40);
    drive(0, 1'b1);
    wait_clks(3 * BIT);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 1, 0);
    wait_clks(BIT);
    chk("3C dat", 32'(dat_m), 32'h3C);

    // overrun: 0x11 held, 0x22 dropped
    ready_m = 1'b0;
    send_frame(0, 8'h11, 0, 1'b0, 1'b1, 1, 0);
    send_frame(0, 8'h22, 0, 1'b0, 1'b1, 0, 0);
    wait_clks(10);
    chk("ovr valid", 32'(valid_m), 32'd1);
    chk("ovr dat", 32'(dat_m), 32'h11);
    chk("ovr flag", 32'(ovr_m), 32'd1);
    ready_m = 1'b1;
    wait_clks(1);
    ready_m = 1'b0;
    chk("ovr valid cleared", 32'(valid_m), 32'd0);
    chk("ovr flag cleared", 32'(ovr_m), 32'd0);
    chk("ovr dat kept", 32'(dat_m), 32'h11);
    ready_m = 1'b1;
    wait_clks(BIT);

    // even parity: 0x07 has three ones
    send_frame(1, 8'h07, 1, 1'b0, 1'b1, 1, 0);
    wait_clks(BIT);
    chk("p 07 par0 dat", 32'(dat_p), 32'h07);
    chk("p 07 par0 perr", 32'(perr_p), 32'd1);
    send_frame(1, 8'h07, 1, 1'b1, 1'b1, 1, 0);
    wait_clks(BIT);
    chk("p 07 par1 perr", 32'(perr_p), 32'd0);
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(1, d, 1, 1'($urandom_range(0, 1)), 1'b1, 1, 0);
      wait_clks($urandom_range(20, 200));
    end
    send_frame(1, 8'hC3, 1, 1'b0, 1'b1, 1, 0);
    wait_clks(BIT);

    // reset during data bit 4 of 0x55; the low bit 5 then looks like a new start
    pat = 8'h55;
    drive(0, 1'b0);
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      drive(0, pat[i]);
      wait_clks(BIT);
    end
    drive(0, pat[4]);
    wait_clks(80);
    rst = 1'b1;
    wait_clks(1);
    chk("midreset dat_o", 32'(dat_m), 32'd0);
    chk("midreset valid_o", 32'(valid_m), 32'd0);
    chk("midreset frame_err", 32'(ferr_m), 32'd0);
    chk("midreset overrun", 32'(ovr_m), 32'd0);
    chk("midreset p dat_o", 32'(dat_p), 32'd0);
    chk("midreset p parity_err", 32'(perr_p), 32'd0);
    rst = 1'b0;
    wait_clks(BIT - 81);
    // bits 5..7 = 0,1,0 then stop 1 and idle: start=bit5, data 1,0,1,1,1,1,1,1
    e.data = 8'hFD; e.perr = 1'b0; e.ferr = 1'b0; e.start = cyc;
    q_m.push_back(e);
    for (int i = 5; i < 8; i++) begin
      drive(0, pat[i]);
      wait_clks(BIT);
    end
    drive(0, 1'b1);
    wait_clks(12 * BIT);
    send_frame(0, 8'h55, 0, 1'b0, 1'b1, 1, 0);
    wait_clks(BIT);
    chk("55 after reset dat", 32'(dat_m), 32'h55);

    wait_clks(200);
    chk("m words outstanding", 32'(q_m.size()), 32'd0);
    chk("p words outstanding", 32'(q_p.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
